multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM state codes, opcodes,
// ALU control values and the grouped strobe bundle.
package multicycle_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_STORE = 2;
  localparam int unsigned OP_JUMP  = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_BEQ   = 5;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_CMP  = 2'b11;

  localparam int unsigned WAIT_W = 8;

  typedef struct packed {
    logic ir_load;
    logic pc_inc;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic busy;
    logic fault;
  } strobe_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: cleared on entry to a waiting state, counts cycles
// without mem_ready and flags the cycle on which the limit is reached.
module mem_wait_timer
  import multicycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              count_en,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expires on the wait cycle that brings the count up to the limit.
  assign expired = count_en && (({1'b0, cnt_q} + 1'b1) >= {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM; BRANCH_COND_EN adds the BEQ opcode and zero input.
//   state  | meaning
//   IDLE   | not running, busy=0
//   FETCH  | read instruction, wait for mem_ready
//   DECODE | register opcode, check legality
//   EXEC   | ALU op / jump / address phase
//   MEM    | data read (LOAD) or write (STORE), wait for mem_ready
//   WB     | register write-back for LOAD
//   FAULT  | illegal opcode or memory timeout, sticky until reset
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
`ifdef BRANCH_COND_EN
  input  logic            zero,
`endif
  output logic            ir_load,
  output logic            pc_inc,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      alu_ctrl,
  output logic [2:0]      state
);

  localparam logic [OP_W-1:0] OPC_ADD   = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0] OPC_LOAD  = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] OPC_STORE = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] OPC_JUMP  = OP_W'(OP_JUMP);
  localparam logic [OP_W-1:0] OPC_SUB   = OP_W'(OP_SUB);
`ifdef BRANCH_COND_EN
  localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(OP_BEQ);
`endif

  logic [2:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [2:0]      next_instr;
  logic            op_legal;
  logic            wait_clear, wait_en, wait_expired;
  strobe_t         sb;

  assign next_instr = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    op_legal = (op == OPC_ADD) || (op == OPC_LOAD) || (op == OPC_STORE) ||
               (op == OPC_JUMP) || (op == OPC_SUB);
`ifdef BRANCH_COND_EN
    if (op == OPC_BEQ) op_legal = 1'b1;
`endif
  end

  always_comb begin
    op_d = op_q;
    if (state_q == ST_DECODE) op_d = op;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        if (mem_ready)         state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_DECODE: state_d = op_legal ? ST_EXEC : ST_FAULT;
      ST_EXEC: begin
        if (op_q == OPC_LOAD || op_q == OPC_STORE) state_d = ST_MEM;
        else                                       state_d = next_instr;
      end
      ST_MEM: begin
        // mem_ready takes priority over a timeout landing in the same cycle
        if (mem_ready)         state_d = (op_q == OPC_LOAD) ? ST_WB : next_instr;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_WB:     state_d = next_instr;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  assign wait_en    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign wait_clear = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

  mem_wait_timer u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wait_clear),
    .count_en (wait_en),
    .limit    (WAIT_W'(MEM_TIMEOUT)),
    .expired  (wait_expired)
  );

  always_comb begin
    sb       = '0;
    alu_ctrl = ALU_PASS;
    case (state_q)
      ST_IDLE: ;
      ST_FETCH: begin
        sb.busy     = 1'b1;
        sb.mem_read = 1'b1;
        sb.ir_load  = mem_ready;
        sb.pc_inc   = mem_ready;
      end
      ST_DECODE: sb.busy = 1'b1;
      ST_EXEC: begin
        sb.busy = 1'b1;
        if (op_q == OPC_ADD) begin
          alu_ctrl     = ALU_ADD;
          sb.reg_write = 1'b1;
        end else if (op_q == OPC_SUB) begin
          alu_ctrl     = ALU_SUB;
          sb.reg_write = 1'b1;
        end else if (op_q == OPC_JUMP) begin
          sb.branch = 1'b1;
        end
`ifdef BRANCH_COND_EN
        else if (op_q == OPC_BEQ) begin
          alu_ctrl  = ALU_CMP;
          sb.branch = zero;
        end
`endif
      end
      ST_MEM: begin
        sb.busy      = 1'b1;
        sb.mem_read  = (op_q == OPC_LOAD);
        sb.mem_write = (op_q == OPC_STORE);
      end
      ST_WB: begin
        sb.busy      = 1'b1;
        sb.reg_write = 1'b1;
      end
      default: begin
        sb.busy  = 1'b1;
        sb.fault = 1'b1;
      end
    endcase
  end

  assign ir_load   = sb.ir_load;
  assign pc_inc    = sb.pc_inc;
  assign reg_write = sb.reg_write;
  assign mem_read  = sb.mem_read;
  assign mem_write = sb.mem_write;
  assign branch    = sb.branch;
  assign busy      = sb.busy;
  assign fault     = sb.fault;
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors
// are queued with the stimulus and compared on the falling clock edge.
module tb_multicycle_control;

  localparam int OP_W        = 3;
  localparam int MEM_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic            mem_ready = 1'b0;
  logic            zero_i = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic            ir_load, pc_inc, reg_write, mem_read, mem_write, branch, busy, fault;
  logic [1:0]      alu_ctrl;
  logic [2:0]      state;

  int    errors = 0;
  int    checks = 0;
  string cur = "init";
  logic [12:0] exp_q[$];

  // {state, ir_load, pc_inc, reg_write, mem_read, mem_write, branch, busy, fault, alu_ctrl}
  localparam logic [12:0] V_IDLE  = {3'd0, 8'b0000_0000, 2'b00};
  localparam logic [12:0] V_FWAIT = {3'd1, 8'b0001_0010, 2'b00};
  localparam logic [12:0] V_FRDY  = {3'd1, 8'b1101_0010, 2'b00};
  localparam logic [12:0] V_DEC   = {3'd2, 8'b0000_0010, 2'b00};
  localparam logic [12:0] V_ADD   = {3'd3, 8'b0010_0010, 2'b01};
  localparam logic [12:0] V_SUB   = {3'd3, 8'b0010_0010, 2'b10};
  localparam logic [12:0] V_JMP   = {3'd3, 8'b0000_0110, 2'b00};
  localparam logic [12:0] V_XLS   = {3'd3, 8'b0000_0010, 2'b00};
  localparam logic [12:0] V_MLD   = {3'd4, 8'b0001_0010, 2'b00};
  localparam logic [12:0] V_MST   = {3'd4, 8'b0000_1010, 2'b00};
  localparam logic [12:0] V_WB    = {3'd5, 8'b0010_0010, 2'b00};
  localparam logic [12:0] V_FLT   = {3'd6, 8'b0000_0011, 2'b00};
`ifdef BRANCH_COND_EN
  localparam logic [12:0] V_BEQ1  = {3'd3, 8'b0000_0110, 2'b11};
  localparam logic [12:0] V_BEQ0  = {3'd3, 8'b0000_0010, 2'b11};
`endif

  wire [12:0] obs = {state, ir_load, pc_inc, reg_write, mem_read, mem_write,
                     branch, busy, fault, alu_ctrl};

  multicycle_control #(.OP_W(OP_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .op        (op),
    .mem_ready (mem_ready),
`ifdef BRANCH_COND_EN
    .zero      (zero_i),
`endif
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .busy      (busy),
    .fault     (fault),
    .alu_ctrl  (alu_ctrl),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    check("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(cur, {19'b0, obs}, {19'b0, e});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic [OP_W-1:0] o, input logic rdy,
                      input logic z, input logic [12:0] e);
    run       = r;
    op        = o;
    mem_ready = rdy;
    zero_i    = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    op        = '0;
    zero_i    = 1'b0;
    #1;
    check("rst_idle", {19'b0, obs}, {19'b0, V_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cur = "reset";
    do_reset();

    cur = "idle_hold";
    step(0, 0, 0, 0, V_IDLE);
    step(0, 0, 1, 0, V_IDLE);

    cur = "add";
    step(1, 0, 1, 0, V_IDLE);
    step(1, 0, 1, 0, V_FRDY);
    step(1, 0, 1, 0, V_DEC);
    step(1, 0, 1, 0, V_ADD);
    cur = "sub";
    step(1, 4, 1, 0, V_FRDY);
    step(1, 4, 1, 0, V_DEC);
    step(1, 4, 1, 0, V_SUB);
    cur = "jump";
    step(1, 3, 1, 0, V_FRDY);
    step(1, 3, 1, 0, V_DEC);
    step(1, 3, 1, 0, V_JMP);

    cur = "load_wait";
    step(1, 1, 1, 0, V_FRDY);
    step(1, 1, 0, 0, V_DEC);
    step(1, 1, 0, 0, V_XLS);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, V_MLD);
    step(1, 1, 1, 0, V_MLD);
    step(1, 1, 0, 0, V_WB);

    cur = "store_run_drop";
    step(1, 2, 1, 0, V_FRDY);
    step(1, 2, 0, 0, V_DEC);
    step(1, 2, 0, 0, V_XLS);
    for (int i = 0; i < 3; i++) step(0, 2, 0, 0, V_MST);
    step(0, 2, 1, 0, V_MST);
    step(0, 2, 0, 0, V_IDLE);
    step(0, 2, 1, 0, V_IDLE);

    cur = "store_zero_wait";
    step(1, 2, 1, 0, V_IDLE);
    step(1, 2, 1, 0, V_FRDY);
    step(1, 2, 1, 0, V_DEC);
    step(1, 2, 1, 0, V_XLS);
    step(1, 2, 1, 0, V_MST);
    cur = "load_zero_wait";
    step(1, 1, 1, 0, V_FRDY);
    step(1, 1, 1, 0, V_DEC);
    step(1, 1, 1, 0, V_XLS);
    step(1, 1, 1, 0, V_MLD);
    step(0, 1, 1, 0, V_WB);
    step(0, 1, 1, 0, V_IDLE);

    cur = "illegal_op7";
    step(1, 7, 1, 0, V_IDLE);
    step(1, 7, 1, 0, V_FRDY);
    step(1, 7, 1, 0, V_DEC);
    step(1, 7, 1, 0, V_FLT);
    step(0, 0, 1, 0, V_FLT);
    do_reset();

`ifdef BRANCH_COND_EN
    cur = "beq_zero1";
    step(1, 5, 1, 1, V_IDLE);
    step(1, 5, 1, 1, V_FRDY);
    step(1, 5, 1, 1, V_DEC);
    step(1, 5, 1, 1, V_BEQ1);
    cur = "beq_zero0";
    step(1, 5, 1, 0, V_FRDY);
    step(1, 5, 1, 0, V_DEC);
    step(0, 5, 1, 0, V_BEQ0);
    step(0, 5, 1, 0, V_IDLE);
`else
    cur = "op5_no_beq";
    step(1, 5, 1, 1, V_IDLE);
    step(1, 5, 1, 1, V_FRDY);
    step(1, 5, 1, 1, V_DEC);
    step(1, 5, 1, 1, V_FLT);
    step(1, 0, 1, 0, V_FLT);
    do_reset();
`endif

    cur = "ready_at_limit";
    step(1, 0, 0, 0, V_IDLE);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1, 0, 0, 0, V_FWAIT);
    step(1, 0, 1, 0, V_FRDY);
    step(1, 0, 0, 0, V_DEC);
    step(0, 0, 0, 0, V_ADD);
    step(0, 0, 0, 0, V_IDLE);

    cur = "fetch_timeout";
    step(1, 0, 0, 0, V_IDLE);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 0, 0, 0, V_FWAIT);
    step(1, 0, 1, 0, V_FLT);
    step(0, 1, 1, 0, V_FLT);
    step(1, 2, 0, 0, V_FLT);
    do_reset();
    cur = "after_fault_reset";
    step(0, 0, 0, 0, V_IDLE);

    cur = "mem_timeout";
    step(1, 1, 1, 0, V_IDLE);
    step(1, 1, 1, 0, V_FRDY);
    step(1, 1, 0, 0, V_DEC);
    step(1, 1, 0, 0, V_XLS);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 1, 0, 0, V_MLD);
    step(1, 1, 1, 0, V_FLT);
    do_reset();

    cur = "async_rst_mid_mem";
    step(1, 2, 1, 0, V_IDLE);
    step(1, 2, 1, 0, V_FRDY);
    step(1, 2, 0, 0, V_DEC);
    step(1, 2, 0, 0, V_XLS);
    step(1, 2, 0, 0, V_MST);
    #1;
    check("mid_mem_write_high", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("async_rst_state", {29'b0, state}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    do_reset();
    cur = "final_idle";
    step(0, 0, 0, 0, V_IDLE);

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
